// File: rtl/gpu_smem_pkg.sv
// gpu_smem_pkg: shared definitions for the shared-memory responder.
// It holds the FSM state encodings, the default address and data widths,
// the statistics counter width and a saturating-increment helper.
package gpu_smem_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int STAT_W     = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// gpu_rr_arbiter: combinational round-robin arbiter.
// It grants the first requester at or after the pointer, wrapping past the
// last core. The grant comes out both one-hot and as an index.
module gpu_rr_arbiter #(
    parameter int NUM_CORES = 8,
    localparam int IDX_W    = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk the cores starting at the pointer and stop at the first request
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_CORES)) begin
                sum = sum - (IDX_W+1)'(NUM_CORES);
            end
            cand = sum[IDX_W-1:0];
            if (!any_req && req[cand]) begin
                any_req   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gpu_shared_mem_responder.sv
// gpu_shared_mem_responder: the slave end of the core mem_req/val_data protocol.
// It serves one load or store at a time through a single-port RAM and picks
// the next core round-robin. Defining SMEM_STATS_EN adds saturating counters
// for completed loads and completed stores.
module gpu_shared_mem_responder
    import gpu_smem_pkg::*;
#(
    parameter int NUM_CORES = 8,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          mem_req,
    input  logic [NUM_CORES-1:0]          mem_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr_flat,
    input  logic [NUM_CORES*DATA_W-1:0]   wdat_flat,
    output logic [NUM_CORES-1:0]          val_data,
    output logic [DATA_W-1:0]             mem_dat,
    output logic                          busy
`ifdef SMEM_STATS_EN
    ,
    output logic [STAT_W-1:0]             stat_rd_cnt,
    output logic [STAT_W-1:0]             stat_wr_cnt
`endif
);

    localparam int IDX_W  = $clog2(NUM_CORES);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_CORES-1:0] gnt_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdat_q;

    logic [NUM_CORES-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdat;

    logic                 in_range;
    logic [RAM_AW-1:0]    ram_idx;
    logic [DATA_W-1:0]    ram [0:DEPTH-1];

    gpu_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .req     (mem_req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // Pull the granted core's opcode, address and store data out of the flat buses
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_wdat = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (arb_gnt[k]) begin
                sel_we   = mem_we[k];
                sel_addr = addr_flat[k*ADDR_W +: ADDR_W];
                sel_wdat = wdat_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
    assign ram_idx  = addr_q[RAM_AW-1:0];

    // Three-state access sequencer: latch a grant, touch the RAM, then pulse completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            busy      <= 1'b0;
            val_data  <= '0;
            mem_dat   <= '0;
        end else begin
            val_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q     <= arb_gnt;
                        gnt_idx_q <= arb_idx;
                        we_q      <= sel_we;
                        addr_q    <= sel_addr;
                        wdat_q    <= sel_wdat;
                        busy      <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        mem_dat <= in_range ? ram[ram_idx] : '0;
                    end
                    val_data <= gnt_q;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    rr_ptr <= (gnt_idx_q == IDX_W'(NUM_CORES-1)) ? '0 : gnt_idx_q + 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port; a reset forces the state to idle, so it also cancels a pending write
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && we_q && in_range) begin
            ram[ram_idx] <= wdat_q;
        end
    end

`ifdef SMEM_STATS_EN
    // Count completed accesses by type, saturating at the top of the range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else if (state == ST_RESP) begin
            if (we_q) begin
                stat_wr_cnt <= sat_inc(stat_wr_cnt);
            end else begin
                stat_rd_cnt <= sat_inc(stat_rd_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpu_shared_mem_responder.sv
// tb_gpu_shared_mem_responder: scoreboard bench for the shared-memory responder.
// A reference model works out the round-robin service order and the data
// each core should see. The monitor pops those expectations as completions
// arrive and also checks response latency and spacing.
module tb_gpu_shared_mem_responder;

    localparam int NC    = 8;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     mem_req;
    logic [NC-1:0]     mem_we;
    logic [NC*AW-1:0]  addr_flat;
    logic [NC*DW-1:0]  wdat_flat;
    logic [NC-1:0]     val_data;
    logic [DW-1:0]     mem_dat;
    logic              busy;
`ifdef SMEM_STATS_EN
    logic [15:0]       stat_rd_cnt;
    logic [15:0]       stat_wr_cnt;
`endif

    gpu_shared_mem_responder #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_flat (addr_flat),
        .wdat_flat (wdat_flat),
        .val_data  (val_data),
        .mem_dat   (mem_dat),
        .busy      (busy)
`ifdef SMEM_STATS_EN
        ,
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC-1:0] onehot;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    int             compared    = 0;
    int             mismatched  = 0;
    int             cyc         = 0;
    int             last_pulse  = 0;
    int             batch_start = 0;
    bit             batch_first = 1'b0;

    logic           c_we   [NC];
    logic [AW-1:0]  c_addr [NC];
    logic [DW-1:0]  c_wdat [NC];
    logic [DW-1:0]  mdl_mem [0:(1<<AW)-1];
    int             mdl_ptr;
    logic [DW-1:0]  mdl_last;
    logic [AW-1:0]  known_addr [3];

    // Free-running cycle counter used for latency and spacing checks
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setCore(input int k, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdat);
        c_we[k]   = we;
        c_addr[k] = addr;
        c_wdat[k] = wdat;
    endtask

    task automatic driveFlats();
        for (int k = 0; k < NC; k++) begin
            mem_we[k]             = c_we[k];
            addr_flat[k*AW +: AW] = c_addr[k];
            wdat_flat[k*DW +: DW] = c_wdat[k];
        end
    endtask

    task automatic modelServe(input int k);
        exp_t e;
        e.onehot    = '0;
        e.onehot[k] = 1'b1;
        if (c_we[k]) begin
            if (int'(c_addr[k]) < DEPTH) mdl_mem[c_addr[k]] = c_wdat[k];
            e.dat = mdl_last;
        end else begin
            mdl_last = (int'(c_addr[k]) < DEPTH) ? mdl_mem[c_addr[k]] : '0;
            e.dat    = mdl_last;
        end
        exp_q.push_back(e);
        mdl_ptr = (k + 1) % NC;
    endtask

    task automatic applyStimulus(input logic [NC-1:0] mask);
        logic [NC-1:0] pending;
        int            n;
        pending = mask;
        driveFlats();
        while (pending != '0) begin
            for (int i = 0; i < NC; i++) begin
                int k;
                k = (mdl_ptr + i) % NC;
                if (pending[k]) begin
                    modelServe(k);
                    pending[k] = 1'b0;
                    break;
                end
            end
        end
        batch_first = 1'b1;
        batch_start = cyc;
        mem_req     = mask;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            mem_req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        mem_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        mdl_ptr  = 0;
        mdl_last = '0;
    endtask

    // Completion monitor: pop the scoreboard, check timing, and drop the served request
    always @(negedge clk) begin
        if (!reset && val_data != '0) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_val_data", 32'(val_data), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("val_data", 32'(val_data), 32'(mon_e.onehot));
                checkOutput("mem_dat", 32'(mem_dat), 32'(mon_e.dat));
                if (batch_first) begin
                    checkOutput("latency", 32'(cyc - batch_start), 32'd2);
                    batch_first = 1'b0;
                end else begin
                    checkOutput("spacing", 32'(cyc - last_pulse), 32'd3);
                end
                last_pulse = cyc;
            end
            mem_req = mem_req & ~val_data;
        end
    end

    initial begin
        reset     = 1'b1;
        mem_req   = '0;
        mem_we    = '0;
        addr_flat = '0;
        wdat_flat = '0;
        for (int k = 0; k < NC; k++) setCore(k, 1'b0, '0, '0);
        mdl_ptr  = 0;
        mdl_last = '0;
        known_addr[0] = 12'h0A5;
        known_addr[1] = 12'h020;
        known_addr[2] = 12'h100;

        repeat (3) @(negedge clk);
        checkOutput("reset_val_data", 32'(val_data), 32'd0);
        checkOutput("reset_mem_dat", 32'(mem_dat), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
`ifdef SMEM_STATS_EN
        checkOutput("reset_stat_rd", 32'(stat_rd_cnt), 32'd0);
        checkOutput("reset_stat_wr", 32'(stat_wr_cnt), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Core 3 stores then reads back the same word
        setCore(3, 1'b1, 12'h0A5, 8'h5C);
        applyStimulus(8'h08);
        setCore(3, 1'b0, 12'h0A5, 8'h00);
        applyStimulus(8'h08);

        // Core 7 alone moves the pointer to 0, then cores 0, 2 and 5 request together
        setCore(7, 1'b1, 12'h100, 8'hA7);
        applyStimulus(8'h80);
        setCore(0, 1'b0, 12'h0A5, 8'h00);
        setCore(2, 1'b1, 12'h020, 8'h22);
        setCore(5, 1'b0, 12'h100, 8'h00);
        applyStimulus(8'h25);

        // Pointer is now 6; all eight cores load at once and service wraps around
        for (int k = 0; k < NC; k++) setCore(k, 1'b0, known_addr[k % 3], 8'h00);
        applyStimulus(8'hFF);

        // Out-of-range addresses: loads read zero and stores must not alias into the RAM
        setCore(4, 1'b1, 12'h7FF, 8'h11);
        applyStimulus(8'h10);
        setCore(4, 1'b0, 12'hFFF, 8'h00);
        applyStimulus(8'h10);
        setCore(4, 1'b1, 12'hFFF, 8'h99);
        applyStimulus(8'h10);
        setCore(4, 1'b0, 12'h7FF, 8'h00);
        applyStimulus(8'h10);
        setCore(4, 1'b0, 12'hFFF, 8'h00);
        applyStimulus(8'h10);

        // Reset lands during the ACCESS cycle of a store; the store must be lost
        setCore(1, 1'b1, 12'h010, 8'h33);
        applyStimulus(8'h02);
        setCore(1, 1'b1, 12'h010, 8'h7E);
        driveFlats();
        mem_req = 8'h02;
        @(posedge clk);
        #1;
        checkOutput("busy_at_grant", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("busy_in_reset", 32'(busy), 32'd0);
        checkOutput("val_data_in_reset", 32'(val_data), 32'd0);
        mem_req = '0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        mdl_ptr  = 0;
        mdl_last = '0;
        repeat (5) @(negedge clk);
        checkOutput("busy_after_reset", 32'(busy), 32'd0);
        checkOutput("mem_dat_after_reset", 32'(mem_dat), 32'd0);
        setCore(1, 1'b0, 12'h010, 8'h00);
        applyStimulus(8'h02);

`ifdef SMEM_STATS_EN
        // Three loads and two stores in one batch, then reset clears the counters
        doReset();
        checkOutput("stat_rd_cleared", 32'(stat_rd_cnt), 32'd0);
        checkOutput("stat_wr_cleared", 32'(stat_wr_cnt), 32'd0);
        setCore(0, 1'b0, 12'h0A5, 8'h00);
        setCore(1, 1'b0, 12'h0A5, 8'h00);
        setCore(2, 1'b0, 12'h0A5, 8'h00);
        setCore(3, 1'b1, 12'h030, 8'h31);
        setCore(4, 1'b1, 12'h031, 8'h32);
        applyStimulus(8'h1F);
        checkOutput("stat_rd_count", 32'(stat_rd_cnt), 32'd3);
        checkOutput("stat_wr_count", 32'(stat_wr_cnt), 32'd2);
        doReset();
        checkOutput("stat_rd_reset", 32'(stat_rd_cnt), 32'd0);
        checkOutput("stat_wr_reset", 32'(stat_wr_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
